// File: rtl/sdr_meas_pkg.sv
// Shared constants and FSM state type for the sample-domain measurement blocks.
package sdr_meas_pkg;

  localparam int unsigned INT_W_DEF  = 10;
  localparam int unsigned FRAC_W_DEF = 22;
  localparam int unsigned T_W        = 18;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure,
    StDone
  } meas_state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse train plus rising-edge detect.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pulse_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the mean interval between rising edges of pulse_in over 2^avg_log2 intervals,
// reporting it as an integer/fractional cycle count.
module pulse_period_meter
  import sdr_meas_pkg::*;
#(
  parameter int unsigned INT_W        = INT_W_DEF,
  parameter int unsigned FRAC_W       = FRAC_W_DEF,
  parameter int unsigned AVG_MAX_LOG2 = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              start,
  input  logic              cont,
  input  logic [2:0]        avg_log2,
  output logic [INT_W-1:0]  period_int,
  output logic [FRAC_W-1:0] period_frac,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned I_W = INT_W + 1;
  localparam int unsigned E_W = AVG_MAX_LOG2 + 1;

  logic rise;

  pulse_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  meas_state_e       state_q, state_d;
  logic [2:0]        avg_q, avg_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [I_W-1:0]    i_q, i_d;
  logic [E_W-1:0]    e_q, e_d;
  logic [INT_W-1:0]  pint_q, pint_d;
  logic [FRAC_W-1:0] pfrac_q, pfrac_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [T_W-1:0]    t_cap, int_full, rem_mask;
  logic [FRAC_W-1:0] frac_val;
  logic [E_W-1:0]    n_target;
  logic              ovf;

  // T including the cycle of the terminating edge.
  always_comb begin
    t_cap    = t_q + T_W'(1);
    int_full = t_cap >> avg_q;
    rem_mask = ~({T_W{1'b1}} << avg_q);
    frac_val = FRAC_W'(t_cap & rem_mask) << (FRAC_W - 32'(avg_q));
    ovf      = (int_full >> INT_W) != '0;
    n_target = E_W'(1) << avg_q;
  end

  always_comb begin
    state_d = state_q;
    avg_d   = avg_q;
    t_d     = t_q;
    i_d     = i_q;
    e_d     = e_q;
    pint_d  = pint_q;
    pfrac_d = pfrac_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          avg_d   = (32'(avg_log2) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : avg_log2;
          err_d   = 1'b0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (rise) begin
          t_d     = '0;
          i_d     = '0;
          e_d     = '0;
          state_d = StMeasure;
        end
      end
      StMeasure, StDone: begin
        t_d = t_q + T_W'(1);
        i_d = rise ? I_W'(1) : i_q + I_W'(1);
        if (state_q == StDone) begin
          // The terminating edge already re-armed the counters, so no interval is lost.
          state_d = cont ? StMeasure : StIdle;
        end else if (rise) begin
          e_d = e_q + E_W'(1);
          if (e_d == n_target) begin
            if (ovf) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              pint_d  = int_full[INT_W-1:0];
              pfrac_d = frac_val;
              valid_d = 1'b1;
              state_d = StDone;
            end
            t_d = '0;
            i_d = '0;
            e_d = '0;
          end
        end else if (i_q[INT_W]) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      avg_q   <= '0;
      t_q     <= '0;
      i_q     <= '0;
      e_q     <= '0;
      pint_q  <= '0;
      pfrac_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      avg_q   <= avg_d;
      t_q     <= t_d;
      i_q     <= i_d;
      e_q     <= e_d;
      pint_q  <= pint_d;
      pfrac_q <= pfrac_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign period_int  = pint_q;
  assign period_frac = pfrac_q;
  assign valid       = valid_q;
  assign err         = err_q;
  assign busy        = (state_q == StArm) || (state_q == StMeasure);

endmodule
